pip_regfile: RTL and testbench



---
 rtl/pip_regfile_if.sv | 16 +
 rtl/pip_regfile.sv | 34 +++
 tb/tb_pip_regfile.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pip_regfile_if.sv
// pip_regfile_if: writeback/read bus for pip_regfile.
// slave modport is the register file; master modport is the pipeline side.
// Ports: wb_data/wb_ad/wb_en (MEM/WB writeback), rs1_ad/rs2_ad (ID read addresses),
//        rs1_data/rs2_data (combinational read data), wb_count (commits since reset).
interface pip_regfile_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_ad;
  logic            wb_en;
  logic [4:0]      rs1_ad;
  logic [4:0]      rs2_ad;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [31:0]     wb_count;
  modport slave (input wb_data, wb_ad, wb_en, rs1_ad, rs2_ad, output rs1_data, rs2_data, wb_count);
  modport master (output wb_data, wb_ad, wb_en, rs1_ad, rs2_ad, input rs1_data, rs2_data, wb_count);
endinterface

// File: rtl/pip_regfile.sv
// pip_regfile: x1..x31 register file, one write port, two combinational read ports with optional write bypass.
// Ports: clk, rst (sync, active-high), bus (pip_regfile_if.slave: writeback in, read addresses in, read data and commit count out).
module pip_regfile #(
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic          clk,
  input logic          rst,
  pip_regfile_if.slave bus
);
  logic [XLEN-1:0] regs_q [1:31];
  logic [31:0]     wb_count_q, wb_count_d;
  logic            commit;
  logic            byp1, byp2;
  always_comb begin
    commit     = bus.wb_en && bus.wb_ad != 5'd0;
    wb_count_d = commit ? wb_count_q + 32'd1 : wb_count_q;
    // x0 is checked first so a write to x0 can never leak through the bypass
    byp1       = BYPASS && bus.wb_en && bus.wb_ad == bus.rs1_ad;
    byp2       = BYPASS && bus.wb_en && bus.wb_ad == bus.rs2_ad;
    bus.rs1_data = bus.rs1_ad == 5'd0 ? '0 : byp1 ? bus.wb_data : regs_q[bus.rs1_ad];
    bus.rs2_data = bus.rs2_ad == 5'd0 ? '0 : byp2 ? bus.wb_data : regs_q[bus.rs2_ad];
    bus.wb_count = wb_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      wb_count_q <= '0;
    end else begin
      if (commit) regs_q[bus.wb_ad] <= bus.wb_data;
      wb_count_q <= wb_count_d;
    end
  end
endmodule

// File: tb/tb_pip_regfile.sv
// tb_pip_regfile: scoreboard bench for pip_regfile, bypass and non-bypass instances driven in lockstep.
module tb_pip_regfile;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pip_regfile_if #(.XLEN(32)) bus_a ();
  pip_regfile_if #(.XLEN(32)) bus_b ();
  pip_regfile #(.XLEN(32), .BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pip_regfile #(.XLEN(32), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic [31:0] r1a, r2a, r1b, r2b, cnt;
    bit          rd;
    string       tag;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mregs [32];
  logic [31:0] mcnt;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a, input bit byp, input bit en,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (byp && en && wa == a) return wd;
    return mregs[a];
  endfunction

  task automatic drive(input string tag, input bit r, input bit en, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus_a.wb_en = en; bus_a.wb_ad = wa; bus_a.wb_data = wd; bus_a.rs1_ad = a1; bus_a.rs2_ad = a2;
    bus_b.wb_en = en; bus_b.wb_ad = wa; bus_b.wb_data = wd; bus_b.rs1_ad = a1; bus_b.rs2_ad = a2;
    e.r1a = mread(a1, 1'b1, en, wa, wd);
    e.r2a = mread(a2, 1'b1, en, wa, wd);
    e.r1b = mread(a1, 1'b0, en, wa, wd);
    e.r2b = mread(a2, 1'b0, en, wa, wd);
    e.cnt = mcnt;
    e.rd  = !r;
    e.tag = tag;
    sb.push_back(e);
    if (r) begin
      foreach (mregs[i]) mregs[i] = 32'd0;
      mcnt = 32'd0;
    end else if (en && wa != 5'd0) begin
      mregs[wa] = wd;
      mcnt = mcnt + 32'd1;
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, " cnt_byp"}, bus_a.wb_count, e.cnt);
        chk({e.tag, " cnt_nobyp"}, bus_b.wb_count, e.cnt);
        if (e.rd) begin
          chk({e.tag, " rs1_byp"}, bus_a.rs1_data, e.r1a);
          chk({e.tag, " rs2_byp"}, bus_a.rs2_data, e.r2a);
          chk({e.tag, " rs1_nobyp"}, bus_b.rs1_data, e.r1b);
          chk({e.tag, " rs2_nobyp"}, bus_b.rs2_data, e.r2b);
        end
      end
    end
  end

  initial begin
    foreach (mregs[i]) mregs[i] = 32'd0;
    mcnt = 32'd0;
    rst = 1'b1;
    bus_a.wb_en = 1'b0; bus_a.wb_ad = '0; bus_a.wb_data = '0; bus_a.rs1_ad = '0; bus_a.rs2_ad = '0;
    bus_b.wb_en = 1'b0; bus_b.wb_ad = '0; bus_b.wb_data = '0; bus_b.rs1_ad = '0; bus_b.rs2_ad = '0;
    drive("init_rst", 1, 0, 0, 0, 0, 0);
    drive("init_rst", 1, 0, 0, 0, 0, 0);
    drive("post_rst", 0, 0, 0, 0, 5, 31);
    drive("wr_x5", 0, 1, 5, 32'hDEADBEEF, 5, 0);
    drive("rd_x5", 0, 0, 0, 0, 5, 5);
    drive("rst_clr", 1, 0, 0, 0, 5, 5);
    drive("rd_clr", 0, 0, 0, 0, 5, 5);
    drive("wr_x1", 0, 1, 1, 32'h11111111, 0, 0);
    drive("wr_x31", 0, 1, 31, 32'hFFFF0000, 1, 0);
    drive("rd_x1_x31", 0, 0, 0, 0, 1, 31);
    drive("x0_wr", 0, 1, 0, 32'h12345678, 0, 0);
    drive("x0_rd", 0, 0, 0, 0, 0, 1);
    drive("wr_x7a", 0, 1, 7, 32'hA, 7, 7);
    drive("byp_x7b", 0, 1, 7, 32'hB, 7, 7);
    drive("rd_x7b", 0, 0, 0, 0, 7, 7);
    drive("rst_vs_wr", 1, 1, 3, 32'h55, 3, 3);
    drive("rd_x3", 0, 0, 0, 0, 3, 3);
    @(negedge clk);
    #1;
    force dut_a.wb_count_q = 32'hFFFFFFFE;
    force dut_b.wb_count_q = 32'hFFFFFFFE;
    #1;
    release dut_a.wb_count_q;
    release dut_b.wb_count_q;
    mcnt = 32'hFFFFFFFE;
    drive("wrap0", 0, 1, 9, 32'h1, 9, 0);
    drive("wrap1", 0, 1, 9, 32'h2, 9, 0);
    drive("wrap2", 0, 1, 10, 32'h3, 9, 10);
    drive("wrap3", 0, 0, 0, 0, 9, 10);
    drive("wrap_rst", 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++)
      drive("rand", $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 31) < 20 ? $urandom_range(0, 7) : $urandom_range(0, 31)),
            $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
